// File: rtl/acia_host_ctrl_if.sv
// acia_host_ctrl_if: requester streams, rx output stream and 6850 register bus of the ACIA host controller
interface acia_host_ctrl_if;
  logic [7:0] tx0_data;
  logic       tx0_valid;
  logic       tx0_ready;
  logic [7:0] tx1_data;
  logic       tx1_valid;
  logic       tx1_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] rx_err;
  logic       acia_E;
  logic       acia_sel;
  logic       acia_rs;
  logic       acia_rw;
  logic [7:0] acia_din;
  logic [7:0] acia_dout;
  logic       acia_irq;
  logic       busy;
  modport master (
    input  tx0_data, tx0_valid, tx1_data, tx1_valid, acia_dout, acia_irq,
    output tx0_ready, tx1_ready, rx_data, rx_valid, rx_err,
           acia_E, acia_sel, acia_rs, acia_rw, acia_din, busy
  );
  modport slave (
    output tx0_data, tx0_valid, tx1_data, tx1_valid, acia_dout, acia_irq,
    input  tx0_ready, tx1_ready, rx_data, rx_valid, rx_err,
           acia_E, acia_sel, acia_rs, acia_rw, acia_din, busy
  );
endinterface

// File: rtl/acia_host_ctrl.sv
// acia_host_ctrl: 6850 ACIA sequencer/arbiter -- init, status polling, round-robin tx, rx drain.
// Define ACIA_HOST_CTRL_IRQ_EN to let a synchronized acia_irq cut the poll gap short.
module acia_host_ctrl #(
  parameter logic [7:0] CR_VALUE = 8'h95,
  parameter logic [7:0] POLL_GAP = 8'd32
) (
  input logic              clk,
  input logic              reset_n,
  acia_host_ctrl_if.master bus
);
  typedef enum logic [2:0] {RST_W, CFG_W, GAP, POLL, RX_R, TX_W} state_t;
  state_t     r_st, w_nst, w_gap_st;
  logic [1:0] r_ph, w_nph;
  logic [7:0] r_cnt;
  logic [1:0] r_err;
  logic       r_last, r_early;
  logic       w_end, w_tmr, w_irq, w_tx_ok, w_win, w_grant, w_rxd;
`ifdef ACIA_HOST_CTRL_IRQ_EN
  logic [1:0] r_irq_s;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_irq_s <= 2'b00;
    else r_irq_s <= {r_irq_s[0], bus.acia_irq};
  assign w_irq = r_irq_s[1];
`else
  assign w_irq = 1'b0;
`endif
  // r_ph: 0 = bus idle, 1/2/3 = A/S/H of the current bus cycle
  always_comb begin
    w_end    = r_ph == 2'd3;
    w_tmr    = r_cnt >= POLL_GAP;
    w_gap_st = (POLL_GAP == 8'd0) ? POLL : GAP;
    w_tx_ok  = bus.acia_dout[1] && (bus.tx0_valid || bus.tx1_valid) && !r_early;
    w_win    = (bus.tx0_valid && bus.tx1_valid) ? !r_last : bus.tx1_valid;
    w_nst    = r_st;
    case (r_st)
      RST_W:       if (w_end) w_nst = CFG_W;
      CFG_W, TX_W: if (w_end) w_nst = w_gap_st;
      GAP:         if (w_tmr || w_irq) w_nst = POLL;
      POLL:        if (w_end) w_nst = bus.acia_dout[0] ? RX_R : w_tx_ok ? TX_W : w_gap_st;
      RX_R:        if (w_end) w_nst = POLL;
      default:     w_nst = RST_W;
    endcase
    w_nph   = (w_nst == GAP) ? 2'd0 : (w_end || r_ph == 2'd0) ? 2'd1 : r_ph + 2'd1;
    w_grant = r_st == POLL && w_nst == TX_W;
    w_rxd   = r_st == RX_R && w_end;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st          <= RST_W;
      r_ph          <= 2'd0;
      r_cnt         <= 8'd1;
      r_err         <= 2'b00;
      r_last        <= 1'b1;
      r_early       <= 1'b0;
      bus.acia_E    <= 1'b0;
      bus.acia_sel  <= 1'b0;
      bus.acia_rs   <= 1'b0;
      bus.acia_rw   <= 1'b1;
      bus.acia_din  <= 8'h00;
      bus.tx0_ready <= 1'b0;
      bus.tx1_ready <= 1'b0;
      bus.rx_valid  <= 1'b0;
      bus.rx_data   <= 8'h00;
      bus.rx_err    <= 2'b00;
      bus.busy      <= 1'b1;
    end else begin
      r_st          <= w_nst;
      r_ph          <= w_nph;
      r_cnt         <= (r_st == GAP) ? r_cnt + 8'd1 : 8'd1;
      r_err         <= (r_st == POLL && w_end) ? {bus.acia_dout[5], bus.acia_dout[4]} : r_err;
      r_last        <= w_grant ? w_win : r_last;
      // an irq-triggered poll only drains rx; tx stays on the timer cadence
      r_early       <= (r_st == GAP && w_nst == POLL) ? !w_tmr : (r_st == POLL && w_end) ? 1'b0 : r_early;
      bus.acia_sel  <= w_nph != 2'd0;
      bus.acia_E    <= w_nph[1];
      bus.acia_rs   <= w_nst == RX_R || w_nst == TX_W;
      bus.acia_rw   <= !(w_nst == RST_W || w_nst == CFG_W || w_nst == TX_W);
      bus.acia_din  <= (w_nst == RST_W) ? 8'h03 : (w_nst == CFG_W) ? CR_VALUE :
                       w_grant ? (w_win ? bus.tx1_data : bus.tx0_data) : bus.acia_din;
      bus.tx0_ready <= w_grant && !w_win;
      bus.tx1_ready <= w_grant && w_win;
      bus.rx_valid  <= w_rxd;
      bus.rx_data   <= w_rxd ? bus.acia_dout : bus.rx_data;
      bus.rx_err    <= w_rxd ? r_err : bus.rx_err;
      bus.busy      <= w_nst != GAP;
    end
  end
endmodule

// File: doc/acia_host_ctrl.md
# acia_host_ctrl

Sequencer and arbiter sitting between two byte-stream requesters (port 0: IO controller, port 1: MIDI/cart logic) and the 6850-style ACIA register bus. Generates the E strobe and sel/rs/rw/din cycles, performs master reset and configuration, polls status, pushes transmit bytes round-robin from the two requesters, and drains received bytes to a single output stream with error flags.

## Interface
- `CR_VALUE`, default 8'h95: control word written after master reset (rx irq on, tx irq off, 8N1, ÷16).
- `POLL_GAP`, default 8'd32: idle clocks between status polls.
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `tx0_data`, input, 8: requester 0 byte.
- `tx0_valid`, input, 1: requester 0 byte valid.
- `tx0_ready`, output, 1: requester 0 byte accepted this cycle.
- `tx1_data`, input, 8: requester 1 byte.
- `tx1_valid`, input, 1: requester 1 byte valid.
- `tx1_ready`, output, 1: requester 1 byte accepted this cycle.
- `rx_data`, output, 8: received byte.
- `rx_valid`, output, 1: one-cycle pulse, `rx_data` valid.
- `rx_err`, output, 2: {overrun, frame error} captured with the byte.
- `acia_E`, output, 1: bus strobe; the ACIA acts on its rising edge.
- `acia_sel`, output, 1: chip select.
- `acia_rs`, output, 1: 0 = CR/status, 1 = data.
- `acia_rw`, output, 1: 1 = read.
- `acia_din`, output, 8: write data to ACIA.
- `acia_dout`, input, 8: read data from ACIA (combinational, valid while sel & rw).
- `acia_irq`, input, 1: ACIA interrupt.
- `busy`, output, 1: high outside IDLE/GAP.

## Operation
- Bus cycle: 3 clocks, A/S/H. A: sel/rs/rw/din driven, E=0. S: E=1. H: E=1, read data sampled into internal register at end of H. Next clock E=0, sel=0. Signals stable through A..H.
- States: RST_W (write CR=8'h03) → CFG_W (write CR=CR_VALUE) → GAP → POLL → {RX_R | TX_W | GAP}.
- GAP: counts POLL_GAP clocks, then POLL. Counter 8-bit, POLL_GAP=0 means immediate.
- POLL: read status (rs=0). Decision on sampled status s: s[0]=1 → RX_R (rx priority); else s[1]=1 and any txN_valid → TX_W; else GAP.
- RX_R: read data (rs=1); at end of H: `rx_data`=sample, `rx_err`={s[5],s[4]} from preceding poll, `rx_valid` pulses one clock; then POLL directly (no gap).
- TX_W: winner chosen at POLL exit, round-robin: last-served pointer toggles after each grant; single valid requester always wins. `txN_ready` pulses one clock at POLL exit for the winner; byte latched then and written in TX_W. Then GAP.
- Requester drop of valid before grant: no error, arbiter re-evaluates at next POLL.
- Writes of CR other than RST_W/CFG_W: never issued.

## Timing
- Reset values: acia_E=0, acia_sel=0, acia_rs=0, acia_rw=1, acia_din=0, tx*_ready=0, rx_valid=0, rx_data=0, rx_err=0, busy=1, RR pointer=1 (port 0 first), state RST_W.
- Reset deassertion → first E rise on clock 2 (A at clock 1). RST_W+CFG_W complete after 6 clocks.
- Status-to-rx_valid latency: 6 clocks from POLL A to rx_valid.
- Reset mid-cycle: E and sel drop immediately (asynchronous); full re-init follows.
- Back-to-back rx: POLL/RX_R alternate with no gap while s[0]=1.

## Configuration
- `ACIA_HOST_CTRL_IRQ_EN` defined: GAP exits early to POLL when `acia_irq`=1 (synchronized through 2 flops); tx still polled at POLL_GAP rate.
- Undefined: `acia_irq` ignored; purely timer-driven polling.

## Test plan
- Reset release, ACIA model idle → bus writes 8'h03 then 8'h95 to CR, then status reads every POLL_GAP+3 clocks.
- Status 8'h02, tx0_valid=1 tx0_data=8'hA5 → tx0_ready pulse, data write rs=1 din=8'hA5, GAP follows.
- Both valid continuously, status 8'h02 → grants alternate 0,1,0,1; no port served twice in a row.
- Status 8'h01 and tx0_valid → RX_R first; rx_valid with byte 8'h3C, rx_err=0; tx served after next POLL.
- Status 8'h31 then data 8'h7E → rx_data=8'h7E, rx_err=2'b11.
- reset_n low during S of a TX_W → E, sel 0 same cycle; no tx ready; after release re-init sequence repeats.
